// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the branch/hazard logic and the next-PC sequencer.
// The master side owns the PC and the branch requests; the slave side owns next_pc and the qualifiers.
interface pc_sequencer_if;
    logic [63:0] pc;
    logic [63:0] branch_pc;
    logic [63:0] br_offset;
    logic [63:0] reg_target;
    logic        uncond_br;
    logic        cond_br;
    logic        cond_flag;
    logic        br_reg;
    logic        stall_req;
    logic        halt;
    logic [63:0] next_pc;
    logic        flush;
    logic        fetch_valid;
    logic        halted;

    modport master (
        output pc, branch_pc, br_offset, reg_target,
        output uncond_br, cond_br, cond_flag, br_reg,
        output stall_req, halt,
        input  next_pc, flush, fetch_valid, halted
    );

    modport slave (
        input  pc, branch_pc, br_offset, reg_target,
        input  uncond_br, cond_br, cond_flag, br_reg,
        input  stall_req, halt,
        output next_pc, flush, fetch_valid, halted
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: picks reset vector, pc+4, branch target or hold each cycle
// and sequences boot, stall, post-branch flush and halt.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'd0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic          clk,
    input logic          reset,
    pc_sequencer_if.slave bus
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [3:0] FLUSH_INIT = FLUSH_CYCLES[3:0];

    logic [1:0]  state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic        taken;
    logic [63:0] target;
    logic [63:0] pc_inc;

    assign taken  = bus.uncond_br | (bus.cond_br & bus.cond_flag);
    assign target = bus.br_reg ? bus.reg_target
                               : bus.branch_pc + (bus.br_offset << 2);
    assign pc_inc = bus.pc + 64'd4;

    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        bus.next_pc     = RESET_VECTOR;
        bus.flush       = 1'b0;
        bus.fetch_valid = 1'b0;
        bus.halted      = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                bus.fetch_valid = ~bus.stall_req & ~bus.halt;
                if (bus.halt) begin
                    bus.next_pc = bus.pc;
                    state_d     = S_HALT;
                end else if (taken) begin
                    bus.next_pc = target;
                    if (FLUSH_CYCLES > 0) begin
                        state_d = S_FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end
                end else if (bus.stall_req) begin
                    bus.next_pc = bus.pc;
                end else begin
                    bus.next_pc = pc_inc;
                end
            end
            S_FLUSH: begin
                // Branches and halts here come from squashed instructions.
                bus.flush   = 1'b1;
                bus.next_pc = bus.stall_req ? bus.pc : pc_inc;
                if (!bus.stall_req) begin
                    fcnt_d = fcnt_q - 4'd1;
                    if (fcnt_q <= 4'd1) begin
                        state_d = S_RUN;
                        fcnt_d  = 4'd0;
                    end
                end
            end
            default: begin
                bus.next_pc = bus.pc;
                bus.halted  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: a PC register closes the loop and a
// scoreboard of expected next_pc/flush/fetch_valid/halted is checked each cycle.
module tb_pc_sequencer;

    typedef struct packed {
        logic        ub, cb, cf, br, st, hl;
        logic [63:0] bpc, off, rt, npc;
        logic        fl, fv, ho;
    } row_t;

    typedef struct packed {
        logic [63:0] npc;
        logic        fl, fv, ho;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_VECTOR (64'd0),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register fed by the sequencer.
    always @(posedge clk) bus.pc <= bus.next_pc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic row_t R(
        input logic ub, cb, cf, br, st, hl,
        input logic [63:0] bpc, off, rt, npc,
        input logic fl, fv, ho
    );
        row_t r;
        r = '{ub, cb, cf, br, st, hl, bpc, off, rt, npc, fl, fv, ho};
        return r;
    endfunction

    function automatic row_t idle(
        input logic [63:0] npc, input logic fl, fv, ho
    );
        return R(0, 0, 0, 0, 0, 0, 64'd0, 64'd0, 64'd0, npc, fl, fv, ho);
    endfunction

    task automatic apply(input row_t r);
        @(negedge clk);
        bus.uncond_br  = r.ub;
        bus.cond_br    = r.cb;
        bus.cond_flag  = r.cf;
        bus.br_reg     = r.br;
        bus.stall_req  = r.st;
        bus.halt       = r.hl;
        bus.branch_pc  = r.bpc;
        bus.br_offset  = r.off;
        bus.reg_target = r.rt;
        sb.push_back('{r.npc, r.fl, r.fv, r.ho});
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        reset = 1'b0;
        rows.push_back(idle(64'd0, 0, 0, 0));
        rows.push_back(idle(64'd0, 0, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL reset[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
        reset = 1'b1;
        sb.push_back('{64'd0, 1'b0, 1'b0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
            failures++;
            $display("FAIL boot: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                     bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                     e.npc, e.fl, e.fv, e.ho);
        end
        rows.delete();
        for (int k = 1; k <= 4; k++) rows.push_back(idle(64'(4 * k), 0, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL seq[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
    endtask

    task automatic test_not_taken_reg();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(0, 1, 0, 0, 0, 0, 64'h10, 64'h8, 64'h0, 64'h14, 0, 1, 0));
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h1000, 64'h1000, 0, 1, 0));
        rows.push_back(idle(64'h1004, 1, 0, 0));
        rows.push_back(idle(64'h1008, 1, 0, 0));
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h38, 64'h38, 0, 1, 0));
        rows.push_back(idle(64'h3C, 1, 0, 0));
        rows.push_back(idle(64'h40, 1, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL notaken_reg[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
    endtask

    task automatic test_pc_relative();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(0, 1, 1, 0, 0, 0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC,
                         64'h0, 64'h30, 0, 1, 0));
        rows.push_back(idle(64'h34, 1, 0, 0));
        rows.push_back(idle(64'h38, 1, 0, 0));
        rows.push_back(idle(64'h3C, 0, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL pcrel[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
    endtask

    task automatic test_stall_flush();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h18, 64'h18, 0, 1, 0));
        rows.push_back(idle(64'h1C, 1, 0, 0));
        rows.push_back(idle(64'h20, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            rows.push_back(R(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h20, 0, 0, 0));
        rows.push_back(R(1, 0, 0, 1, 1, 0, 64'h0, 64'h0, 64'h200, 64'h200, 0, 0, 0));
        rows.push_back(R(0, 0, 0, 0, 1, 0, 64'h0, 64'h0, 64'h0, 64'h200, 1, 0, 0));
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h999, 64'h204, 1, 0, 0));
        rows.push_back(R(0, 0, 0, 0, 0, 1, 64'h0, 64'h0, 64'h0, 64'h208, 1, 0, 0));
        rows.push_back(idle(64'h20C, 0, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL stall_flush[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
    endtask

    task automatic test_halt_wrap();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF4,
                         64'hFFFF_FFFF_FFFF_FFF4, 0, 1, 0));
        rows.push_back(idle(64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0));
        rows.push_back(idle(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0));
        rows.push_back(idle(64'h0, 0, 1, 0));
        rows.push_back(R(1, 0, 0, 1, 0, 1, 64'h0, 64'h0, 64'h500, 64'h0, 0, 0, 0));
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h500, 64'h0, 0, 0, 1));
        rows.push_back(R(0, 1, 1, 0, 1, 0, 64'h0, 64'h10, 64'h0, 64'h0, 0, 0, 1));
        rows.push_back(idle(64'h0, 0, 0, 1));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL halt_wrap[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
        #2;
        reset = 1'b0;
        sb.push_back('{64'd0, 1'b0, 1'b0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
            failures++;
            $display("FAIL halt_reset: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                     bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                     e.npc, e.fl, e.fv, e.ho);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        apply(idle(64'h4, 0, 1, 0));
        e = sb.pop_front();
        checks++;
        if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
            failures++;
            $display("FAIL halt_reboot: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                     bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                     e.npc, e.fl, e.fv, e.ho);
        end
    endtask

    task automatic test_async_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back(R(1, 0, 0, 1, 0, 0, 64'h0, 64'h0, 64'h80, 64'h80, 0, 1, 0));
        rows.push_back(idle(64'h84, 1, 0, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL pre_reset[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
        #2;
        reset = 1'b0;
        sb.push_back('{64'd0, 1'b0, 1'b0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
            failures++;
            $display("FAIL async_reset: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                     bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                     e.npc, e.fl, e.fv, e.ho);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        sb.push_back('{64'd0, 1'b0, 1'b0, 1'b0});
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
            failures++;
            $display("FAIL reboot: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                     bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                     e.npc, e.fl, e.fv, e.ho);
        end
        rows.delete();
        rows.push_back(idle(64'h4, 0, 1, 0));
        rows.push_back(idle(64'h8, 0, 1, 0));
        foreach (rows[i]) begin
            apply(rows[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.next_pc, bus.flush, bus.fetch_valid, bus.halted} !== e) begin
                failures++;
                $display("FAIL post_reset[%0d]: got npc=%h fl=%b fv=%b hl=%b want npc=%h fl=%b fv=%b hl=%b",
                         i, bus.next_pc, bus.flush, bus.fetch_valid, bus.halted,
                         e.npc, e.fl, e.fv, e.ho);
            end
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b0;
        bus.pc         = 64'd0;
        bus.branch_pc  = 64'd0;
        bus.br_offset  = 64'd0;
        bus.reg_target = 64'd0;
        bus.uncond_br  = 1'b0;
        bus.cond_br    = 1'b0;
        bus.cond_flag  = 1'b0;
        bus.br_reg     = 1'b0;
        bus.stall_req  = 1'b0;
        bus.halt       = 1'b0;
        test_reset();
        test_not_taken_reg();
        test_pc_relative();
        test_stall_flush();
        test_halt_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 64-bit program counter register. Each cycle it chooses the value loaded into the PC: reset vector, PC+4, branch target, register target, or hold. It sequences boot, stall, post-branch flush and halt. It sits between the branch/hazard logic and the PC register. It drives the PC's D input and the fetch-side flush/valid qualifiers.

Parameters:
- RESET_VECTOR, 64'd0, address loaded into the PC on the first cycle after reset release.
- FLUSH_CYCLES, 2, cycles flush is asserted after a taken branch; legal range 0..15.

Ports:
- clk  input  1  system clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- pc  input  64  current PC (PC register output).
- branch_pc  input  64  address of the branch instruction being resolved.
- br_offset  input  64  sign-extended word offset (instructions, not bytes).
- reg_target  input  64  register branch target (BR), byte address.
- uncond_br  input  1  unconditional branch (B/BL/BR) resolved this cycle.
- cond_br  input  1  conditional branch (CBZ/B.cond) resolved this cycle.
- cond_flag  input  1  condition result for cond_br.
- br_reg  input  1  1 = target is reg_target; 0 = PC-relative.
- stall_req  input  1  hazard stall; hold PC.
- halt  input  1  halt request.
- next_pc  output  64  value to load into the PC register next edge.
- flush  output  1  squash in-flight fetched instructions.
- fetch_valid  output  1  the instruction at pc may be issued.
- halted  output  1  sequencer is in HALTED.

Behaviour:
- taken = uncond_br | (cond_br & cond_flag).
- target = br_reg ? reg_target : branch_pc + (br_offset << 2).
- All adds are modulo 2^64; pc + 4 at 64'hFFFF_FFFF_FFFF_FFFC wraps to 0; no overflow flag.
- States are BOOT, RUN, FLUSH and HALTED.
- There is a 4-bit flush counter fcnt.
- Async reset (reset low): state = BOOT, fcnt = 0.
  - Outputs while in reset: next_pc = RESET_VECTOR, flush = 0, fetch_valid = 0, halted = 0.
- BOOT: next_pc = RESET_VECTOR, fetch_valid = 0. Goes to RUN on the next edge unconditionally. All request inputs are ignored.
- RUN: priority is halt > taken > stall_req > sequential.
  - halt: next_pc = pc, go to HALTED.
  - taken: next_pc = target.
    - If FLUSH_CYCLES > 0: go to FLUSH, fcnt = FLUSH_CYCLES.
    - Otherwise stay in RUN.
  - stall_req: next_pc = pc, stay in RUN.
  - else: next_pc = pc + 4.
  - fetch_valid = ~stall_req & ~halt.
- FLUSH: flush = 1, fetch_valid = 0.
  - taken and halt are ignored, because they come from squashed instructions.
  - next_pc = stall_req ? pc : pc + 4.
  - fcnt decrements on each edge where stall_req = 0. When fcnt is 1 and it decrements, go to RUN.
  - A stall therefore extends FLUSH one cycle per stalled cycle.
- HALTED: next_pc = pc, halted = 1, fetch_valid = 0, flush = 0. Only reset leaves this state.
- next_pc, fetch_valid and flush are combinational from state, fcnt and the inputs. No registered latency is added: a decision made in cycle N is loaded into the PC at the end of cycle N.
- Reset asserted mid-FLUSH or mid-HALTED returns immediately (asynchronously) to BOOT outputs.
- Simultaneous taken and stall_req in RUN: the branch wins and the target is loaded.
- Simultaneous halt and taken in RUN: halt wins and the target is discarded.

Test Plan:
- Boot: hold reset = 0 for 2 cycles, then release. Expect next_pc = 0 in reset and BOOT, then pc sequence 0, 4, 8, 12 with fetch_valid = 1 from the first RUN cycle.
- PC-relative branch: at pc = 0x40, assert cond_br = 1, cond_flag = 1, branch_pc = 0x40, br_offset = -4 (64'hFFFF_FFFF_FFFF_FFFC). Expect next_pc = 0x30, then flush = 1 for exactly 2 cycles (pc 0x30, 0x34), then fetch_valid = 1 at pc = 0x38.
- Not-taken and register branch: cond_br = 1, cond_flag = 0 at pc = 0x10 gives next_pc = 0x14. Then uncond_br = 1, br_reg = 1, reg_target = 0x1000 gives next_pc = 0x1000.
- Stall and flush interaction: stall_req = 1 for 3 cycles at pc = 0x20 holds pc = 0x20. Then a taken branch plus stall_req in the first FLUSH cycle gives flush lasting 3 cycles. A taken branch during FLUSH is ignored.
- Halt and wrap: at pc = 64'hFFFF_FFFF_FFFF_FFFC with no requests, next_pc = 0. Assert halt with a simultaneous taken branch: pc holds, halted = 1. Further branches are ignored until reset = 0.
- Async reset mid-FLUSH: drop reset between clock edges. Outputs immediately become next_pc = RESET_VECTOR and flush = 0. After release the sequencer goes through BOOT, then RUN.
